mmap_target: RTL and testbench

Command target for the serial memory-map protocol engine. It consumes the engine's master strobe, command, address and data, and decodes them into two targets: a local bank of configuration registers, or an external memory port with a request/acknowledge handshake. It returns one read word per read request on the engine's slave interface. It sits between the protocol engine and the raycaster's configuration/framebuffer logic.

---
 rtl/mmap_target_pkg.sv | 33 +++
 rtl/mmap_cmd_slot.sv | 35 +++
 rtl/mmap_target.sv | 183 ++++++++++++++++++
 tb/tb_mmap_target.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmap_target_pkg.sv
// Shared constants and types for the memory-map command target.
package mmap_target_pkg;

  localparam int REG_ID        = 0;
  localparam int REG_STATUS    = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TIMEOUT  = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_UNMAPPED = 3;

  localparam logic [5:0]  CMD_REG   = 6'd0;
  localparam logic [5:0]  CMD_MEM   = 6'd1;
  localparam logic [31:0] DEAD_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_RESPOND
  } state_t;

  typedef struct packed {
    logic [5:0]  cmd;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  function automatic logic [31:0] status_word(input logic busy, input logic [3:1] flags);
    return {28'd0, flags, busy};
  endfunction

endpackage

// File: rtl/mmap_cmd_slot.sv
// Single-entry holding buffer for a command that arrives while the target is busy.
module mmap_cmd_slot
  import mmap_target_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic overflow
);

  cmd_t data_reg;
  logic full_reg;

  // A pop and push in the same cycle refills the entry with the new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (push && (!full_reg || pop)) begin
      data_reg <= din;
      full_reg <= 1'b1;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign dout     = data_reg;
  assign full     = full_reg;
  assign overflow = push && full_reg && !pop;

endmodule

// File: rtl/mmap_target.sv
// Decodes protocol-engine commands onto a local register bank or a req/ack memory
// port; one command is buffered while busy and commands complete in arrival order.
module mmap_target
  import mmap_target_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          MEM_AW      = 18,
  parameter int          MEM_TIMEOUT = 1023,
  parameter logic [31:0] ID_WORD     = 32'h52435354
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_new_cmd,
  input  logic                     m_write,
  input  logic [5:0]               m_cmd,
  input  logic [31:0]              m_address,
  input  logic [31:0]              m_data,
  output logic [31:0]              s_data,
  output logic                     s_drdy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ack,
  output logic [32*NUM_REGS-1:0]   cfg,
  output logic [NUM_REGS-1:0]      cfg_wr
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              state_reg;
  logic                mem_req_reg, mem_we_reg, s_drdy_reg;
  logic [MEM_AW-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg, resp_reg, s_data_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [NUM_REGS-1:0] cfg_wr_reg, cfg_wr_next, wr_hit;
  logic [3:1]          flags_reg, flags_next, flags_clr;

  cmd_t        incoming, cur, slot_dout;
  logic        slot_full, slot_overflow, push, pop;
  logic        idle, take, is_reg, is_mem, reg_write, timeout_hit, busy;
  logic [3:0]  reg_idx;
  logic [31:0] reg_rdata;
  logic [31:0] cfg_word [NUM_REGS];
  logic        unused_addr_bits;

  assign incoming = {m_cmd, m_write, m_address, m_data};
  assign idle     = (state_reg == ST_IDLE);
  // The buffered command always goes first so completion order matches arrival order.
  assign take     = idle && (slot_full || m_new_cmd);
  assign cur      = slot_full ? slot_dout : incoming;
  assign push     = m_new_cmd && !(idle && !slot_full);
  assign pop      = idle && slot_full;
  assign busy     = !idle || slot_full;

  assign is_reg    = (cur.cmd == CMD_REG);
  assign is_mem    = (cur.cmd == CMD_MEM);
  assign reg_idx   = cur.addr[3:0];
  assign reg_write = take && is_reg && cur.write;
  assign unused_addr_bits = ^cur.addr;

  assign timeout_hit = (state_reg == ST_MEM_WAIT) && !mem_ack &&
                       (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

  mmap_cmd_slot u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      (incoming),
    .dout     (slot_dout),
    .full     (slot_full),
    .overflow (slot_overflow)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_hit[gi] = reg_write && (reg_idx == 4'(gi));
      if (gi == REG_ID) begin : g_id
        assign cfg_word[gi] = ID_WORD;
      end else if (gi == REG_STATUS) begin : g_status
        assign cfg_word[gi] = status_word(busy, flags_reg);
      end else begin : g_rw
        logic [31:0] data_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            data_reg <= '0;
          else if (wr_hit[gi])
            data_reg <= cur.data;
        end
        assign cfg_word[gi] = data_reg;
      end
      assign cfg[32*gi +: 32] = cfg_word[gi];
    end
  endgenerate

  assign cfg_wr_next = wr_hit & ~(NUM_REGS'(1) << REG_ID);

  // Clear first, then set: a flag event in the clearing cycle still lands.
  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (reg_idx == 4'(i))
        reg_rdata = cfg_word[i];
    flags_clr = '0;
    if (reg_write && reg_idx == 4'(REG_STATUS))
      flags_clr = cur.data[STAT_UNMAPPED:STAT_TIMEOUT];
    flags_next = flags_reg & ~flags_clr;
    if (timeout_hit)
      flags_next[STAT_TIMEOUT] = 1'b1;
    if (slot_overflow)
      flags_next[STAT_OVERFLOW] = 1'b1;
    if (take && !is_reg && !is_mem)
      flags_next[STAT_UNMAPPED] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      wait_cnt_reg  <= '0;
      resp_reg      <= '0;
      s_data_reg    <= '0;
      s_drdy_reg    <= 1'b0;
      cfg_wr_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      s_drdy_reg <= 1'b0;
      cfg_wr_reg <= cfg_wr_next;
      flags_reg  <= flags_next;
      case (state_reg)
        ST_IDLE: begin
          if (take) begin
            if (is_mem) begin
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= cur.write;
              mem_addr_reg  <= cur.addr[MEM_AW-1:0];
              mem_wdata_reg <= cur.data;
              wait_cnt_reg  <= '0;
              state_reg     <= ST_MEM_WAIT;
            end else if (!cur.write) begin
              resp_reg  <= is_reg ? reg_rdata : DEAD_WORD;
              state_reg <= ST_RESPOND;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            resp_reg    <= mem_rdata;
            state_reg   <= mem_we_reg ? ST_IDLE : ST_RESPOND;
          end else if (timeout_hit) begin
            mem_req_reg <= 1'b0;
            resp_reg    <= DEAD_WORD;
            state_reg   <= mem_we_reg ? ST_IDLE : ST_RESPOND;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_RESPOND: begin
          s_drdy_reg <= 1'b1;
          s_data_reg <= resp_reg;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s_data    = s_data_reg;
  assign s_drdy    = s_drdy_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cfg_wr    = cfg_wr_reg;

endmodule

// File: tb/tb_mmap_target.sv
// Randomised transaction bench for mmap_target against a register/flag-level model.
module tb_mmap_target;

  localparam int          NR   = 8;
  localparam int          T    = 20;
  localparam int          AW   = 18;
  localparam int          WIN  = T + 6;
  localparam logic [31:0] ID   = 32'h52435354;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_new_cmd, m_write;
  logic [5:0]        m_cmd;
  logic [31:0]       m_address, m_data;
  logic [31:0]       s_data;
  logic              s_drdy;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_ack;
  logic [32*NR-1:0]  cfg;
  logic [NR-1:0]     cfg_wr;

  int          n_checks = 0;
  int          n_bad    = 0;
  int          ack_lat  = 1;
  logic [31:0] last_rdata = '0;

  logic [31:0] mregs [16];
  logic [3:1]  mflags;

  mmap_target #(
    .NUM_REGS    (NR),
    .MEM_AW      (AW),
    .MEM_TIMEOUT (T),
    .ID_WORD     (ID)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_new_cmd (m_new_cmd),
    .m_write   (m_write),
    .m_cmd     (m_cmd),
    .m_address (m_address),
    .m_data    (m_data),
    .s_data    (s_data),
    .s_drdy    (s_drdy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .cfg       (cfg),
    .cfg_wr    (cfg_wr)
  );

  always #5 clk = ~clk;

  // Memory: acks in the ack_lat-th cycle that mem_req is seen high (0 = never).
  initial begin : responder
    int seen;
    seen = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        seen++;
        if (ack_lat != 0 && seen == ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = $urandom();
          last_rdata = mem_rdata;
        end
      end else begin
        seen = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = '0;
  endtask

  function automatic logic [31:0] mword(input int i);
    if (i == 0) return ID;
    if (i == 1) return {28'd0, mflags, 1'b0};
    if (i < NR) return mregs[i];
    return 32'd0;
  endfunction

  task automatic check_cfg();
    for (int i = 0; i < NR; i++) check_eq("cfg_word", cfg[32*i +: 32], mword(i));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_s_drdy", 32'(s_drdy), 0);
    check_eq("rst_s_data", s_data, 0);
    check_eq("rst_cfg_wr", 32'(cfg_wr), 0);
    check_cfg();
  endtask

  // One command from idle, observed for a fixed window, then judged against the model.
  task automatic txn(input logic [5:0] cmd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input int lat);
    int drdy_cnt, drdy_k, wr_k, wr_cycles, req_cnt, exp_req, exp_k, idx;
    logic [31:0] drdy_data, exp_data, req_wdata;
    logic [NR-1:0] wr_val, exp_wr;
    logic [AW-1:0] req_addr;
    logic req_we, unstable;
    drdy_cnt = 0; drdy_k = -1; wr_k = -1; wr_cycles = 0; req_cnt = 0;
    drdy_data = '0; wr_val = '0; req_addr = '0; req_we = 1'b0; req_wdata = '0; unstable = 1'b0;
    ack_lat = lat;
    @(posedge clk); #1;
    m_new_cmd = 1'b1; m_cmd = cmd; m_write = wr; m_address = addr; m_data = data;
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #2;
      m_new_cmd = 1'b0;
      if (s_drdy) begin drdy_cnt++; drdy_k = k; drdy_data = s_data; end
      if (cfg_wr != '0) begin wr_val = cfg_wr; wr_cycles++; if (wr_k < 0) wr_k = k; end
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
        end else if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata) begin
          unstable = 1'b1;
        end
      end
    end
    exp_data = DEAD; exp_k = 2; exp_wr = '0; exp_req = 0; idx = int'(addr[3:0]);
    if (cmd == 6'd0) begin
      if (wr) begin
        if (idx == 1) begin
          mflags &= ~data[3:1];
          exp_wr = NR'(2);
        end else if (idx >= 2 && idx < NR) begin
          mregs[idx] = data;
          exp_wr = NR'(1) << idx;
        end
      end else begin
        exp_data = mword(idx);
      end
    end else if (cmd == 6'd1) begin
      exp_req = (lat == 0) ? T : lat;
      exp_k = exp_req + 2;
      if (lat == 0) mflags[1] = 1'b1;
      else exp_data = last_rdata;
    end else begin
      mflags[3] = 1'b1;
    end
    $display("txn cmd=%0d wr=%0d addr=%08h data=%08h lat=%0d drdy=%0d@%0d s_data=%08h",
             cmd, wr, addr, data, lat, drdy_cnt, drdy_k, drdy_data);
    check_eq("drdy_count", 32'(drdy_cnt), wr ? 0 : 1);
    if (!wr) begin
      check_eq("drdy_cycle", 32'(drdy_k), 32'(exp_k));
      check_eq("s_data", drdy_data, exp_data);
    end
    check_eq("cfg_wr", 32'(wr_val), 32'(exp_wr));
    if (exp_wr != '0) begin
      check_eq("cfg_wr_cycle", 32'(wr_k), 1);
      check_eq("cfg_wr_len", 32'(wr_cycles), 1);
    end
    check_eq("req_cycles", 32'(req_cnt), 32'(exp_req));
    if (cmd == 6'd1) begin
      check_eq("mem_addr", 32'(req_addr), 32'(addr[AW-1:0]));
      check_eq("mem_we", 32'(req_we), 32'(wr));
      if (wr) check_eq("mem_wdata", req_wdata, data);
      check_eq("mem_stable", 32'(unstable), 0);
    end
    check_cfg();
  endtask

  initial begin : stim
    int drdy_cnt, wr3_k, req_cnt, kind, lat;
    logic [31:0] old3, a, d;
    logic [5:0] c;
    logic w;

    rst_n = 1'b0; m_new_cmd = 1'b0; m_write = 1'b0; m_cmd = '0; m_address = '0; m_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    #1 rst_n = 1'b1;

    txn(6'd0, 1'b0, 32'h0, 32'h0, 1);
    txn(6'd0, 1'b1, 32'h5, 32'h12345678, 1);
    txn(6'd0, 1'b0, 32'h5, 32'h0, 1);
    txn(6'd0, 1'b1, 32'h0, 32'hFFFFFFFF, 1);
    txn(6'd0, 1'b1, 32'h9, 32'hA5A5A5A5, 1);
    txn(6'd0, 1'b0, 32'h9, 32'h0, 1);
    txn(6'd1, 1'b0, 32'h100, 32'h0, 3);
    txn(6'd1, 1'b1, 32'h0ABCD123, 32'h600DF00D, 1);

    // Memory write, register write while waiting, third command overflows.
    txn(6'd0, 1'b1, 32'h1, 32'hE, 1);
    old3 = mword(3);
    ack_lat = 4;
    @(posedge clk); #1;
    m_new_cmd = 1'b1; m_cmd = 6'd1; m_write = 1'b1; m_address = 32'h2A; m_data = 32'h00001111;
    @(posedge clk); #1;
    m_cmd = 6'd0; m_write = 1'b1; m_address = 32'h3; m_data = 32'h33330003;
    @(posedge clk); #1;
    m_cmd = 6'd0; m_write = 1'b0; m_address = 32'h2; m_data = 32'h0;
    @(posedge clk); #1;
    m_new_cmd = 1'b0;
    #1;
    check_eq("pend_hold", cfg[32*3 +: 32], old3);
    check_eq("busy_live", 32'(cfg[32]), 1);
    drdy_cnt = 0; wr3_k = -1;
    for (int k = 4; k <= 30; k++) begin
      @(posedge clk); #2;
      if (s_drdy) drdy_cnt++;
      if (cfg_wr[3] && wr3_k < 0) wr3_k = k;
    end
    mregs[3] = 32'h33330003;
    mflags[2] = 1'b1;
    $display("pending: reg3 write cycle=%0d dropped-read drdy=%0d", wr3_k, drdy_cnt);
    check_eq("pend_wr_cycle", 32'(wr3_k), 6);
    check_eq("drop_no_drdy", 32'(drdy_cnt), 0);
    check_cfg();
    txn(6'd0, 1'b0, 32'h1, 32'h0, 1);
    txn(6'd0, 1'b1, 32'h1, 32'h4, 1);
    check_eq("ovf_cleared", 32'(cfg[32+2]), 0);

    txn(6'd1, 1'b0, 32'h77, 32'h0, 0);
    txn(6'd0, 1'b0, 32'h1, 32'h0, 1);
    txn(6'd7, 1'b0, 32'h3, 32'h0, 1);
    txn(6'd0, 1'b0, 32'h1, 32'h0, 1);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom();
      d = $urandom();
      w = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 4);
      if (kind < 4) c = 6'd0;
      else if (kind < 7) c = 6'd1;
      else if (kind == 7) c = 6'($urandom_range(2, 63));
      else begin c = 6'd0; a = {a[31:4], 4'd1}; w = 1'b1; end
      txn(c, w, a, d, lat);
    end

    // Reset in the middle of a memory wait.
    ack_lat = 0;
    @(posedge clk); #1;
    m_new_cmd = 1'b1; m_cmd = 6'd1; m_write = 1'b0; m_address = 32'h55; m_data = 32'h0;
    repeat (3) begin @(posedge clk); #2; m_new_cmd = 1'b0; end
    check_eq("req_before_rst", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_req", 32'(mem_req), 0);
    model_reset();
    check_reset_outputs();
    @(posedge clk); #3 rst_n = 1'b1;
    drdy_cnt = 0; req_cnt = 0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk); #2;
      if (s_drdy) drdy_cnt++;
      if (mem_req) req_cnt++;
    end
    $display("reset abort: drdy=%0d req_cycles=%0d", drdy_cnt, req_cnt);
    check_eq("abort_no_drdy", 32'(drdy_cnt), 0);
    check_eq("abort_no_req", 32'(req_cnt), 0);
    txn(6'd0, 1'b0, 32'h0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
